// File: rtl/param_pkg.sv
// Shared parameters for the main-memory subsystem and its AXI front-end.
// Contents:
//   MAIN_MEM_AW / MAIN_MEM_DW : memory line-index width / line width
//   AXI_DW / AXI_IDW          : AXI data / ID width on the memory-side port
//   BEATS_PER_LINE / LINE_OFF : AXI beats per line, byte-offset bits per line
//   OKAY / SLVERR             : AXI response codes
//   BURST_INCR                : AXI INCR burst encoding
//   state_e                   : axi_mem_slave FSM states
package param_pkg;
  localparam int MAIN_MEM_AW    = 20;
  localparam int MAIN_MEM_DW    = 512;
  localparam int AXI_DW         = 64;
  localparam int AXI_IDW        = 4;
  localparam int BEATS_PER_LINE = MAIN_MEM_DW / AXI_DW;
  localparam int LINE_OFF       = $clog2(MAIN_MEM_DW / 8);

  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    RD_CAP,
    RD_DATA,
    WR_DATA,
    WR_MEM,
    WR_RESP
  } state_e;
endpackage

// File: rtl/axi_line_buf.sv
// Line buffer between the AXI beat stream and the line-wide memory port.
// Holds one full line plus the current beat index.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   load_en, load_data   : parallel load of a whole line (memory read data)
//   wr_en, wr_data       : write one beat at the current beat index
//   cnt_clr, cnt_inc     : clear / advance the beat index
//   cnt                  : current beat index
//   rd_data              : beat at the current beat index
//   line_out             : whole line (memory write data)
module axi_line_buf #(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  output logic [CNT_W-1:0]  cnt,
  output logic [BEAT_W-1:0] rd_data,
  output logic [LINE_W-1:0] line_out
);
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    // Beat k lives at bits [k*BEAT_W +: BEAT_W], beat 0 at the LSB.
    if (load_en) begin
      line_d = load_data;
    end else if (wr_en) begin
      line_d[cnt_q*BEAT_W +: BEAT_W] = wr_data;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Line contents are reset too: the line drives mem_wdata, which must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign rd_data  = line_q[cnt_q*BEAT_W +: BEAT_W];
  assign line_out = line_q;
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave front-end for the line-wide main memory. Every accepted burst is
// one full-line INCR transfer that maps onto exactly one memory read (rcyc) or
// write (wcyc) cycle; reads and writes are serialized through one FSM.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   s_aw* / s_w* / s_b*             : AXI write address / data / response
//   s_ar* / s_r*                    : AXI read address / data
//   mem_rcyc, mem_raddr, mem_rdata  : memory read port (data valid 1 cycle after rcyc)
//   mem_wcyc, mem_waddr, mem_wdata  : memory write port
module axi_mem_slave
  import param_pkg::*;
#(
  parameter int AXI_AW  = 32,
  parameter int AXI_DW  = param_pkg::AXI_DW,
  parameter int AXI_IDW = param_pkg::AXI_IDW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXI_IDW-1:0]     s_awid,
  input  logic [AXI_AW-1:0]      s_awaddr,
  input  logic [7:0]             s_awlen,
  input  logic [2:0]             s_awsize,
  input  logic [1:0]             s_awburst,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [AXI_DW-1:0]      s_wdata,
  input  logic [AXI_DW/8-1:0]    s_wstrb,
  input  logic                   s_wlast,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [AXI_IDW-1:0]     s_bid,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [AXI_IDW-1:0]     s_arid,
  input  logic [AXI_AW-1:0]      s_araddr,
  input  logic [7:0]             s_arlen,
  input  logic [2:0]             s_arsize,
  input  logic [1:0]             s_arburst,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [AXI_IDW-1:0]     s_rid,
  output logic [AXI_DW-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic                   mem_rcyc,
  output logic [MAIN_MEM_AW-1:0] mem_raddr,
  input  logic [MAIN_MEM_DW-1:0] mem_rdata,
  output logic                   mem_wcyc,
  output logic [MAIN_MEM_AW-1:0] mem_waddr,
  output logic [MAIN_MEM_DW-1:0] mem_wdata
);
  localparam int BEATS    = MAIN_MEM_DW / AXI_DW;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SIZE_ENC = $clog2(AXI_DW / 8);

  function automatic logic req_legal(input logic [LINE_OFF-1:0] off,
                                     input logic [7:0]          len,
                                     input logic [2:0]          size,
                                     input logic [1:0]          burst);
    return (off == '0) && (len == 8'(BEATS - 1)) &&
           (size == 3'(SIZE_ENC)) && (burst == BURST_INCR);
  endfunction

  state_e                 state_q, state_d;
  logic                   prio_q, prio_d;   // 0: read wins a tie, 1: write wins
  logic                   err_q, err_d;
  logic [AXI_IDW-1:0]     id_q, id_d;
  logic [MAIN_MEM_AW-1:0] line_q, line_d;

  logic                   rd_grant, wr_grant;
  logic                   buf_load, buf_wr, cnt_clr, cnt_inc;
  logic                   last_beat, beat_err;
  logic [CNT_W-1:0]       beat_cnt;
  logic [AXI_DW-1:0]      rd_beat;

  // Address bits above the line index do not select anything in this memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{s_araddr[AXI_AW-1:LINE_OFF+MAIN_MEM_AW],
                            s_awaddr[AXI_AW-1:LINE_OFF+MAIN_MEM_AW]};

  assign rd_grant  = s_arvalid && (!s_awvalid || !prio_q);
  assign wr_grant  = s_awvalid && !rd_grant;
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    err_d     = err_q;
    id_d      = id_q;
    line_d    = line_q;
    s_arready = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_rvalid  = 1'b0;
    s_bvalid  = 1'b0;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    beat_err  = 1'b0;
    case (state_q)
      IDLE: begin
        s_arready = rd_grant;
        s_awready = wr_grant;
        if (rd_grant) begin
          id_d    = s_arid;
          line_d  = s_araddr[LINE_OFF +: MAIN_MEM_AW];
          cnt_clr = 1'b1;
          prio_d  = ~prio_q;
          err_d   = !req_legal(s_araddr[LINE_OFF-1:0], s_arlen, s_arsize, s_arburst);
          // An illegal read never touches memory; it streams zero beats instead.
          state_d = err_d ? RD_DATA : RD_MEM;
        end else if (wr_grant) begin
          id_d    = s_awid;
          line_d  = s_awaddr[LINE_OFF +: MAIN_MEM_AW];
          cnt_clr = 1'b1;
          prio_d  = ~prio_q;
          err_d   = !req_legal(s_awaddr[LINE_OFF-1:0], s_awlen, s_awsize, s_awburst);
          state_d = WR_DATA;
        end
      end
      RD_MEM:  state_d = RD_CAP;
      RD_CAP: begin
        buf_load = 1'b1;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WR_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          buf_wr   = 1'b1;
          // Partial strobes, an early wlast, or a missing wlast on the final slot all poison the line.
          beat_err = (s_wstrb != '1) || (s_wlast != last_beat);
          err_d    = err_q || beat_err;
          if (s_wlast) begin
            state_d = (err_q || beat_err) ? WR_RESP : WR_MEM;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WR_MEM:  state_d = WR_RESP;
      WR_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      id_q    <= id_d;
      line_q  <= line_d;
    end
  end

  axi_line_buf #(
    .LINE_W (MAIN_MEM_DW),
    .BEAT_W (AXI_DW),
    .CNT_W  (CNT_W)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (buf_load),
    .load_data (mem_rdata),
    .wr_en     (buf_wr),
    .wr_data   (s_wdata),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc),
    .cnt       (beat_cnt),
    .rd_data   (rd_beat),
    .line_out  (mem_wdata)
  );

  assign s_rid     = id_q;
  assign s_rdata   = (s_rvalid && !err_q) ? rd_beat : '0;
  assign s_rlast   = s_rvalid && last_beat;
  assign s_rresp   = (s_rvalid && err_q) ? SLVERR : OKAY;
  assign s_bid     = id_q;
  assign s_bresp   = (s_bvalid && err_q) ? SLVERR : OKAY;
  assign mem_rcyc  = (state_q == RD_MEM);
  assign mem_wcyc  = (state_q == WR_MEM);
  assign mem_raddr = line_q;
  assign mem_waddr = line_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
`timescale 1ns/1ps
module tb_axi_mem_slave;
  import param_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;
  localparam int LW  = MAIN_MEM_DW;
  localparam int NB  = LW / DW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [IDW-1:0]         s_awid = '0;
  logic [AW-1:0]          s_awaddr = '0;
  logic [7:0]             s_awlen = '0;
  logic [2:0]             s_awsize = '0;
  logic [1:0]             s_awburst = '0;
  logic                   s_awvalid = 1'b0;
  logic                   s_awready;
  logic [DW-1:0]          s_wdata = '0;
  logic [DW/8-1:0]        s_wstrb = '0;
  logic                   s_wlast = 1'b0;
  logic                   s_wvalid = 1'b0;
  logic                   s_wready;
  logic [IDW-1:0]         s_bid;
  logic [1:0]             s_bresp;
  logic                   s_bvalid;
  logic                   s_bready = 1'b0;
  logic [IDW-1:0]         s_arid = '0;
  logic [AW-1:0]          s_araddr = '0;
  logic [7:0]             s_arlen = '0;
  logic [2:0]             s_arsize = '0;
  logic [1:0]             s_arburst = '0;
  logic                   s_arvalid = 1'b0;
  logic                   s_arready;
  logic [IDW-1:0]         s_rid;
  logic [DW-1:0]          s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rlast;
  logic                   s_rvalid;
  logic                   s_rready = 1'b0;
  logic                   mem_rcyc;
  logic [MAIN_MEM_AW-1:0] mem_raddr;
  logic [LW-1:0]          mem_rdata;
  logic                   mem_wcyc;
  logic [MAIN_MEM_AW-1:0] mem_waddr;
  logic [LW-1:0]          mem_wdata;

  always #5 clk = ~clk;

  axi_mem_slave #(.AXI_AW(AW), .AXI_DW(DW), .AXI_IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_rcyc(mem_rcyc), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wcyc(mem_wcyc), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data one cycle after rcyc, write on wcyc.
  logic [LW-1:0] mem_model [0:15];
  always @(posedge clk) begin
    if (mem_rcyc) mem_rdata <= mem_model[mem_raddr[3:0]];
    if (mem_wcyc) mem_model[mem_waddr[3:0]] <= mem_wdata;
  end

  // Memory-port activity monitor.
  int                     rcyc_n = 0, wcyc_n = 0, both_n = 0, rcyc_at = -1, wcyc_at = -1;
  logic [MAIN_MEM_AW-1:0] rcyc_addr = '0, wcyc_addr = '0;
  logic [LW-1:0]          wcyc_data = '0;
  always @(negedge clk) begin
    if (mem_rcyc) begin rcyc_n++; rcyc_at = cyc; rcyc_addr = mem_raddr; end
    if (mem_wcyc) begin wcyc_n++; wcyc_at = cyc; wcyc_addr = mem_waddr; wcyc_data = mem_wdata; end
    if (mem_rcyc && mem_wcyc) both_n++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [1:0]     resp;
    logic [IDW-1:0] id;
  } rbeat_t;
  rbeat_t        rq[$];
  logic [LW-1:0] wq[$];

  task automatic push_read(input logic [LW-1:0] line, input logic [IDW-1:0] id, input logic err);
    rbeat_t b;
    for (int k = 0; k < NB; k++) begin
      b.data = err ? '0 : line[k*DW +: DW];
      b.last = (k == NB - 1);
      b.resp = err ? SLVERR : OKAY;
      b.id   = id;
      rq.push_back(b);
    end
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, output int t);
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = BURST_INCR;
    s_arvalid = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_arready) begin t = cyc; break; end
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    check("ar_handshake", LW'(t >= 0), LW'(1));
  endtask

  task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, output int t);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd3; s_awburst = BURST_INCR;
    s_awvalid = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_awready) begin t = cyc; break; end
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    check("aw_handshake", LW'(t >= 0), LW'(1));
  endtask

  // Sends beats 0..n_send-1 of line; wlast on last_beat, strobe 0xFE on bad_beat.
  task automatic send_w(input logic [LW-1:0] line, input int bad_beat, input int n_send,
                        input int last_beat, output int first_t, output int last_t);
    logic ok;
    first_t = -1; last_t = -1;
    for (int k = 0; k < n_send; k++) begin
      s_wdata  = line[k*DW +: DW];
      s_wstrb  = (k == bad_beat) ? 8'hFE : 8'hFF;
      s_wlast  = (k == last_beat);
      s_wvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_wready) begin
          ok = 1'b1; last_t = cyc;
          if (first_t < 0) first_t = cyc;
          break;
        end
      end
      @(posedge clk); #1;
      check("w_handshake", LW'(ok), LW'(1));
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready toggles 1/0.
  task automatic collect_r(input int mode, output int first);
    int     n, got;
    logic   stalled, pl;
    logic [DW-1:0] pd;
    rbeat_t e;
    n = rq.size(); got = 0; stalled = 1'b0; pd = '0; pl = 1'b0; first = -1;
    for (int i = 0; i < 200 && got < n; i++) begin
      s_rready = (mode == 0) ? 1'b1 : (i % 2 == 0);
      @(negedge clk);
      if (s_rvalid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          check("r_hold_data", LW'(s_rdata), LW'(pd));
          check("r_hold_last", LW'(s_rlast), LW'(pl));
        end
        if (s_rready) begin
          e = rq.pop_front();
          check("rdata", LW'(s_rdata), LW'(e.data));
          check("rlast", LW'(s_rlast), LW'(e.last));
          check("rresp", LW'(s_rresp), LW'(e.resp));
          check("rid", LW'(s_rid), LW'(e.id));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = s_rdata; pl = s_rlast;
        end
      end
      @(posedge clk); #1;
    end
    s_rready = 1'b0;
    check("r_beat_count", LW'(got), LW'(n));
  endtask

  task automatic collect_b(input logic [IDW-1:0] id, input logic [1:0] resp, output int t);
    s_bready = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_bvalid) begin
        t = cyc;
        check("bid", LW'(s_bid), LW'(id));
        check("bresp", LW'(s_bresp), LW'(resp));
        break;
      end
    end
    @(posedge clk); #1;
    s_bready = 1'b0;
    check("b_handshake", LW'(t >= 0), LW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, LW'(dut.state_q), LW'(IDLE));
    check({tag, "_ctrl"}, LW'({s_arready, s_awready, s_wready, s_bvalid, s_rvalid,
                               s_rlast, mem_rcyc, mem_wcyc}), LW'(0));
    check({tag, "_ids"}, LW'({s_rid, s_bid, s_rresp, s_bresp}), LW'(0));
    check({tag, "_rdata"}, LW'(s_rdata), LW'(0));
    check({tag, "_maddr"}, LW'({mem_raddr, mem_waddr}), LW'(0));
    check({tag, "_mwdata"}, mem_wdata, LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] l1, l2, l3;
    int t, t2, first, wf, wl, bt, rc0, wc0;
    for (int k = 0; k < NB; k++) begin
      l1[k*DW +: DW] = 64'(17 * (k + 1));
      l2[k*DW +: DW] = 64'hDEAD_0000_0000_0000 | 64'(k);
      l3[k*DW +: DW] = 64'hC0DE_0000_0000_00A0 + 64'(k);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Legal write of line 1, ID 3
    wc0 = wcyc_n;
    wq.push_back(l1);
    send_aw(4'd3, 32'h40, 8'd7, t);
    send_w(l1, -1, NB, NB - 1, wf, wl);
    check("wready_after_aw", LW'(wf), LW'(t + 1));
    collect_b(4'd3, OKAY, bt);
    check("b_timing", LW'(bt), LW'(wl + 2));
    check("wcyc_count", LW'(wcyc_n), LW'(wc0 + 1));
    check("wcyc_timing", LW'(wcyc_at), LW'(wl + 1));
    check("waddr", LW'(wcyc_addr), LW'(1));
    check("wdata_line", wcyc_data, wq.pop_front());

    // Read back with rready held high
    rc0 = rcyc_n;
    push_read(l1, 4'd5, 1'b0);
    send_ar(4'd5, 32'h40, 8'd7, t);
    collect_r(0, first);
    check("rcyc_count", LW'(rcyc_n), LW'(rc0 + 1));
    check("rcyc_timing", LW'(rcyc_at), LW'(t + 1));
    check("raddr", LW'(rcyc_addr), LW'(1));
    check("rvalid_timing", LW'(first), LW'(t + 3));

    // Read back with rready toggling
    push_read(l1, 4'd6, 1'b0);
    send_ar(4'd6, 32'h40, 8'd7, t);
    collect_r(1, first);
    check("rvalid_timing_tog", LW'(first), LW'(t + 3));

    // Illegal read: arlen = 3
    rc0 = rcyc_n;
    push_read(l1, 4'd2, 1'b1);
    send_ar(4'd2, 32'h40, 8'd3, t);
    collect_r(0, first);
    check("illegal_rd_no_rcyc", LW'(rcyc_n), LW'(rc0));

    // Illegal write: one strobe 0xFE
    wc0 = wcyc_n;
    send_aw(4'd4, 32'h80, 8'd7, t);
    send_w(l2, 2, NB, NB - 1, wf, wl);
    collect_b(4'd4, SLVERR, bt);
    check("illegal_wr_no_wcyc", LW'(wcyc_n), LW'(wc0));

    // Reset during beat 4 of a write
    wc0 = wcyc_n;
    send_aw(4'd7, 32'hC0, 8'd7, t);
    send_w(l3, -1, 4, NB - 1, wf, wl);
    s_wdata = l3[4*DW +: DW]; s_wstrb = 8'hFF; s_wlast = 1'b0; s_wvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrst_no_wcyc", LW'(wcyc_n), LW'(wc0));
    check("midrst_no_b", LW'({s_bvalid, s_wready}), LW'(0));
    @(posedge clk); #1;

    // Simultaneous AR/AW after reset: read first, then write
    s_arid = 4'd8; s_araddr = 32'h40; s_arlen = 8'd7; s_arsize = 3'd3; s_arburst = BURST_INCR;
    s_awid = 4'd9; s_awaddr = 32'hC0; s_awlen = 8'd7; s_awsize = 3'd3; s_awburst = BURST_INCR;
    s_arvalid = 1'b1; s_awvalid = 1'b1;
    @(negedge clk);
    check("arb1_grant", LW'({s_arready, s_awready}), LW'(2'b10));
    t = cyc;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    push_read(l1, 4'd8, 1'b0);
    collect_r(0, first);
    check("arb1_rvalid_timing", LW'(first), LW'(t + 3));
    s_arvalid = 1'b1;
    @(negedge clk);
    check("arb2_grant", LW'({s_arready, s_awready}), LW'(2'b01));
    t2 = cyc;
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0;
    wc0 = wcyc_n;
    wq.push_back(l3);
    send_w(l3, -1, NB, NB - 1, wf, wl);
    check("arb2_wready", LW'(wf), LW'(t2 + 1));
    collect_b(4'd9, OKAY, bt);
    check("post_rst_wcyc", LW'(wcyc_n), LW'(wc0 + 1));
    check("post_rst_waddr", LW'(wcyc_addr), LW'(3));
    check("post_rst_wdata", wcyc_data, wq.pop_front());

    // Read the post-reset write back
    push_read(l3, 4'd10, 1'b0);
    send_ar(4'd10, 32'hC0, 8'd7, t);
    collect_r(0, first);
    check("rcyc_wcyc_overlap", LW'(both_n), LW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
